// File: rtl/csync_decoder.sv
// -----------------------------------------------------------------------------
// csync_decoder
//
// Receive-side sync stripper for a composite-sync link. Each csync pulse is
// classified by its width as a glitch, a horizontal pulse or a broad
// (vertical) pulse. The block recovers pixel and line position from these
// pulses, measures the line period and reports when the period is stable.
//
// Ports
//   clock     in   system clock, all logic on the rising edge
//   reset     in   synchronous active-high reset, clears all state
//   csync     in   composite sync, 1 = sync asserted
//   cblank    in   composite blank, 1 = blanked
//   hs_pulse  out  one-cycle strobe per qualified horizontal pulse
//   vs_pulse  out  one-cycle strobe per qualified broad pulse
//   pix_x     out  clocks since the last hs_pulse (saturating)
//   line_y    out  horizontal pulses since the last vs_pulse (saturating)
//   line_len  out  last measured line period in clocks
//   locked    out  line period stable
//   active    out  locked and not blanked
// -----------------------------------------------------------------------------
module csync_decoder #(
    parameter int CNT_W      = 10,
    parameter int HSYNC_MIN  = 4,
    parameter int VSYNC_MIN  = 32,
    parameter int LOCK_LINES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             csync,
    input  logic             cblank,
    output logic             hs_pulse,
    output logic             vs_pulse,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] line_y,
    output logic [CNT_W-1:0] line_len,
    output logic             locked,
    output logic             active
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_MIN   = CNT_W'(HSYNC_MIN);
    localparam logic [CNT_W-1:0] V_MIN   = CNT_W'(VSYNC_MIN);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_LINES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Input capture and pulse width measurement
    logic             csync_q, csync_qq, cblank_q;
    logic [CNT_W-1:0] width_q, width_d;
    logic             h_evt_q, v_evt_q;
    logic             fall, is_h, is_v;

    // Position tracking
    logic             hs_q, vs_q, active_q;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] line_y_q, line_y_d;
    logic [CNT_W-1:0] period_q;

    // Lock tracking
    state_t           state_q;
    logic [3:0]       match_q;
    logic [CNT_W-1:0] line_len_q;
    logic             locked_q;
    logic             skip_q;

    // NOTE: every signal written in an always_comb gets a default at the top of
    // the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fall     = 1'b0;
        is_h     = 1'b0;
        is_v     = 1'b0;
        width_d  = '0;
        pix_d    = pix_q;
        line_y_d = line_y_q;

        // Width is only meaningful while the registered sync is high; it still
        // holds the full pulse width in the cycle the falling edge is seen.
        if (csync_q) begin
            width_d = (width_q == CNT_MAX) ? width_q : width_q + 1'b1;
        end

        fall = csync_qq & ~csync_q;
        is_v = fall && (width_q >= V_MIN);
        is_h = fall && (width_q >= H_MIN) && (width_q < V_MIN);

        if (h_evt_q) begin
            pix_d = '0;
        end else if (pix_q != CNT_MAX) begin
            pix_d = pix_q + 1'b1;
        end

        if (v_evt_q) begin
            line_y_d = '0;
        end else if (h_evt_q && (line_y_q != CNT_MAX)) begin
            line_y_d = line_y_q + 1'b1;
        end
    end

    // Stage 1: input registers, width counter and pulse classification.
    // NOTE: clocked state is always updated with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            csync_q  <= 1'b0;
            csync_qq <= 1'b0;
            cblank_q <= 1'b0;
            width_q  <= '0;
            h_evt_q  <= 1'b0;
            v_evt_q  <= 1'b0;
        end else begin
            csync_q  <= csync;
            csync_qq <= csync_q;
            cblank_q <= cblank;
            width_q  <= width_d;
            h_evt_q  <= is_h;
            v_evt_q  <= is_v;
        end
    end

    // Stage 2: strobes, position counters and the captured line period.
    // period_q holds clocks since the previous strobe for the lock FSM, which
    // acts one cycle later, after pix_x has already restarted at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            pix_q    <= '0;
            line_y_q <= '0;
            period_q <= '0;
            active_q <= 1'b0;
        end else begin
            hs_q     <= h_evt_q;
            vs_q     <= v_evt_q;
            pix_q    <= pix_d;
            line_y_q <= line_y_d;
            if (h_evt_q) begin
                period_q <= pix_q + 1'b1;
            end
            active_q <= locked_q & ~cblank_q;
        end
    end

    // Stage 3: lock FSM with registered locked flag and line period.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            match_q    <= '0;
            line_len_q <= '0;
            locked_q   <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            if (hs_q) begin
                case (state_q)
                    ST_SEARCH: begin
                        state_q <= ST_MEASURE;
                        match_q <= '0;
                        skip_q  <= 1'b0;
                    end
                    ST_MEASURE: begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else if (period_q == line_len_q) begin
                            match_q <= match_q + 4'd1;
                            if (match_q + 4'd1 == LOCK_N) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            line_len_q <= period_q;
                            match_q    <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else if (period_q != line_len_q) begin
                            line_len_q <= period_q;
                            match_q    <= '0;
                            state_q    <= ST_MEASURE;
                            locked_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ST_SEARCH;
                        match_q  <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end else if ((pix_q == CNT_MAX) && !h_evt_q) begin
                // No horizontal pulse for a whole counter span: signal lost.
                // A pulse already in flight takes priority over saturation.
                state_q  <= ST_SEARCH;
                match_q  <= '0;
                locked_q <= 1'b0;
            end

            // A broad pulse makes the next horizontal pulse restart the
            // period measurement without comparing it.
            if (vs_q) begin
                skip_q <= 1'b1;
            end
        end
    end

    assign hs_pulse = hs_q;
    assign vs_pulse = vs_q;
    assign pix_x    = pix_q;
    assign line_y   = line_y_q;
    assign line_len = line_len_q;
    assign locked   = locked_q;
    assign active   = active_q;

endmodule

// File: doc/csync_decoder.md
# csync_decoder

Sync-stripper and timing recovery block; it is the receive end of the video sync generator's composite-sync output. It samples a composite sync stream and classifies each pulse by width as horizontal, broad (vertical) or glitch. From those pulses it recovers pixel and line position, measures the line period and reports lock. It sits at the display/monitor side of the sync link and feeds downstream pixel logic with position and an active-video qualifier.

## Interface
- CNT_W, 10, width of all counters (width, period, pix_x, line_y)
- HSYNC_MIN, 4, minimum pulse width in clocks to qualify as horizontal sync
- VSYNC_MIN, 32, minimum pulse width in clocks to qualify as broad (vertical) pulse; must be > HSYNC_MIN
- LOCK_LINES, 4, consecutive matching periods required to assert lock (1..15)

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- csync  in  1  composite sync, 1 = sync asserted; asynchronous to pixel content, synchronous to clock
- cblank  in  1  composite blank, 1 = blanked
- hs_pulse  out  1  one-cycle strobe per qualified horizontal pulse
- vs_pulse  out  1  one-cycle strobe per qualified broad pulse
- pix_x  out  CNT_W  clocks since last hs_pulse, saturating
- line_y  out  CNT_W  qualified H pulses since last vs_pulse, saturating
- line_len  out  CNT_W  last measured line period in clocks
- locked  out  1  line period stable
- active  out  1  locked and not blanked

## Operation
- csync and cblank are registered once (csync_q, cblank_q); a second stage csync_qq is used for edge detection.
- Width counter:
  - cleared when csync_q = 0;
  - increments each cycle csync_q = 1, saturating at 2^CNT_W-1.
- Falling edge (csync_qq = 1, csync_q = 0) classifies the pulse by the width counter value W:
  - W >= VSYNC_MIN: broad pulse.
  - HSYNC_MIN <= W < VSYNC_MIN: H pulse.
  - W < HSYNC_MIN: glitch; no state change, counters keep running.
- Broad pulse:
  - vs_pulse = 1; line_y <= 0.
  - Sets a skip flag, so the next H pulse restarts the period counter without a comparison.
  - pix_x is not reset; lock state is unchanged.
- H pulse:
  - hs_pulse = 1; pix_x <= 0.
  - line_y <= line_y + 1, saturating.
  - Period P = pix_x + 1 (clocks since the previous hs_pulse) feeds the lock FSM.
- Lock FSM, with match counter M and period register line_len:
  - SEARCH (reset state):
    - H pulse -> MEASURE; M <= 0; no comparison.
  - MEASURE, on H pulse:
    - skip set: clear skip, no compare.
    - else if P == line_len: M <= M + 1; when M + 1 == LOCK_LINES -> LOCKED.
    - else: line_len <= P; M <= 0.
  - LOCKED, on H pulse:
    - skip set: clear skip.
    - P == line_len: stay.
    - P != line_len: line_len <= P; M <= 0; -> MEASURE.
  - Any state: pix_x reaching 2^CNT_W-1 (no H pulse for a full counter span) -> SEARCH; M <= 0; line_len kept.
- locked = (state == LOCKED).
- active = locked & ~cblank_q.
- If an H pulse and saturation occur in the same cycle, the H pulse wins.

## Timing
- Reset values: hs_pulse = 0, vs_pulse = 0, pix_x = 0, line_y = 0, line_len = 0, locked = 0, active = 0; FSM = SEARCH; skip = 0; width counter = 0.
- All outputs are registered.
- First clock edge sampling csync = 0 after a pulse is E0. hs_pulse or vs_pulse is high in the cycle after edge E2 (2-clock latency), for exactly one cycle.
- pix_x reads 0 in the same cycle as hs_pulse, 1 in the next cycle, and so on.
- Consecutive hs_pulses P clocks apart give line_len = P, updated in the cycle after the mismatching hs_pulse.
- locked rises in the cycle after the hs_pulse that completes LOCK_LINES matches. It falls in the cycle after a mismatching hs_pulse or saturation.
- active follows cblank with 2 cycles of latency (input register plus output register).
- Width and period measurements are exact; pulses back-to-back with one low cycle are each classified.
- Reset mid-line or mid-pulse: every register returns to its reset value on the next edge. A pulse in progress during reset is measured only from reset release.

## Test plan
Defaults CNT_W=10, HSYNC_MIN=4, VSYNC_MIN=32, LOCK_LINES=4.
- Reset: hold reset 3 cycles with csync toggling -> every output 0; no strobes during reset.
- Lock acquisition: H pulses of width 8, period 100 -> hs_pulse every 100 clocks; line_len = 100 after pulse 2; locked = 1 the cycle after pulse 6; pix_x cycles 0..99.
- Glitch and broad pulse while locked:
  - 2-clock pulse mid-line -> no strobe; pix_x continues; locked stays 1.
  - Width-40 pulse -> vs_pulse once; line_y = 0; next H pulse not compared; locked stays 1.
- Period change: locked at 100, then period 101 -> locked = 0 the cycle after the first 101-period hs_pulse; line_len = 101; relocks after 4 more matching lines.
- Loss of signal: csync held 0 for 1100 clocks -> pix_x saturates at 1023; FSM to SEARCH; locked = 0; line_len keeps its value.
- Boundary widths and active: widths 3/4/31/32 -> glitch/H/H/broad respectively. With locked = 1, toggling cblank -> active follows with 2-cycle latency.
